// File: rtl/string_hw_pkg.sv
// Shared types and constants for the String HW blocks.
// A FIFO word carries four 8-bit characters, char 0 in the most significant byte.
package string_hw_pkg;

    localparam int CHARS_PER_WORD = 4;
    localparam int CHAR_W         = 8;
    localparam logic [7:0] NUL_CHAR = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } cmp_state_t;

    // Element 0 maps to bits [31:24], so char order follows FIFO byte order.
    typedef logic [0:3][7:0] str_word_t;

endpackage

// File: rtl/string_word_cmp.sv
// Combinational strcmp step over one word pair.
// Scans chars 0..3 and reports the first mismatch or shared NUL.
module string_word_cmp
    import string_hw_pkg::*;
(
    input  str_word_t   a_word,
    input  str_word_t   b_word,
    output logic        stop,
    output logic        is_mismatch,
    output logic [1:0]  pos,
    output logic        lt
);

    always_comb begin
        stop        = 1'b0;
        is_mismatch = 1'b0;
        pos         = 2'd0;
        lt          = 1'b0;
        for (int i = 0; i < CHARS_PER_WORD; i++) begin
            if (!stop) begin
                // A NUL on only one side lands here and sorts as the lesser char.
                if (a_word[i] != b_word[i]) begin
                    stop        = 1'b1;
                    is_mismatch = 1'b1;
                    pos         = 2'(i);
                    lt          = (a_word[i] < b_word[i]);
                end else if (a_word[i] == NUL_CHAR) begin
                    stop = 1'b1;
                    pos  = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/string_compare_engine.sv
// Pops word pairs from queues A and B and compares them strcmp-style.
// Reports equal / less / limit and the byte index where the scan stopped.
//
//  state  | meaning
//  S_IDLE | after reset, waiting for go
//  S_RUN  | busy; compares one word pair per cycle when both queues are valid
//  S_DONE | result valid and held; go starts a new comparison
module string_compare_engine
    import string_hw_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 16,
    parameter int IDX_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_pop,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_pop,
    output logic              busy,
    output logic              done,
    output logic              equal,
    output logic              a_lt_b,
    output logic              limit_hit,
    output logic [IDX_W-1:0]  stop_index
);

    localparam int WCNT_W = $clog2(MAX_WORDS);

    cmp_state_t        state;
    logic [WCNT_W-1:0] word_cnt;

    str_word_t  a_word;
    str_word_t  b_word;
    logic       cmp_stop;
    logic       cmp_mismatch;
    logic [1:0] cmp_pos;
    logic       cmp_lt;
    logic       fire;
    logic       last_word;

    assign a_word = a_data;
    assign b_word = b_data;

    string_word_cmp u_word_cmp (
        .a_word      (a_word),
        .b_word      (b_word),
        .stop        (cmp_stop),
        .is_mismatch (cmp_mismatch),
        .pos         (cmp_pos),
        .lt          (cmp_lt)
    );

    // Both sides pop together or not at all so the strings never drift apart.
    assign fire      = (state == S_RUN) && a_valid && b_valid;
    assign a_pop     = fire;
    assign b_pop     = fire;
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign last_word = (word_cnt == WCNT_W'(MAX_WORDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            equal      <= 1'b0;
            a_lt_b     <= 1'b0;
            limit_hit  <= 1'b0;
            stop_index <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state      <= S_RUN;
                        word_cnt   <= '0;
                        equal      <= 1'b0;
                        a_lt_b     <= 1'b0;
                        limit_hit  <= 1'b0;
                        stop_index <= '0;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        if (cmp_stop) begin
                            state      <= S_DONE;
                            equal      <= !cmp_mismatch;
                            a_lt_b     <= cmp_mismatch && cmp_lt;
                            stop_index <= IDX_W'({word_cnt, cmp_pos});
                        end else if (last_word) begin
                            state      <= S_DONE;
                            equal      <= 1'b1;
                            limit_hit  <= 1'b1;
                            stop_index <= IDX_W'(CHARS_PER_WORD * MAX_WORDS - 1);
                        end else begin
                            word_cnt <= word_cnt + WCNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_string_compare_engine.sv
// Bench for string_compare_engine: directed cases plus random strings
// checked against a flat byte-scan reference model.
module tb_string_compare_engine;

    localparam int MAX_WORDS = 16;
    localparam int NBYTES    = 4 * MAX_WORDS;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        a_valid;
    logic [31:0] a_data;
    logic        a_pop;
    logic        b_valid;
    logic [31:0] b_data;
    logic        b_pop;
    logic        busy;
    logic        done;
    logic        equal;
    logic        a_lt_b;
    logic        limit_hit;
    logic [5:0]  stop_index;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  sa [NBYTES];
    logic [7:0]  sb [NBYTES];
    logic [31:0] qa [$];
    logic [31:0] qb [$];

    always #5 clk = ~clk;

    string_compare_engine #(.DATA_W(32), .MAX_WORDS(MAX_WORDS), .IDX_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_pop      (a_pop),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_pop      (b_pop),
        .busy       (busy),
        .done       (done),
        .equal      (equal),
        .a_lt_b     (a_lt_b),
        .limit_hit  (limit_hit),
        .stop_index (stop_index)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // '.' in a directed string stands for NUL; bytes past the string take fill.
    task automatic put_str(input bit side_b, input string s, input logic [7:0] fill);
        logic [7:0] c;
        for (int k = 0; k < NBYTES; k++) begin
            c = (k < s.len()) ? s[k] : fill;
            if (c == ".") c = 8'h00;
            if (side_b) sb[k] = c;
            else        sa[k] = c;
        end
    endtask

    task automatic load_queues();
        qa.delete();
        qb.delete();
        for (int w = 0; w < MAX_WORDS; w++) begin
            qa.push_back({sa[4*w], sa[4*w+1], sa[4*w+2], sa[4*w+3]});
            qb.push_back({sb[4*w], sb[4*w+1], sb[4*w+2], sb[4*w+3]});
        end
    endtask

    // mode 0: no stalls, 1: random stalls and stray go, 2: B stalled first 3 cycles
    task automatic run_case(input string name, input int mode);
        logic       e_eq, e_lt, e_lim, stopped, sta, stb, last_pop;
        int         e_idx, e_pops, npops, cyc;
        e_eq = 1'b1; e_lt = 1'b0; e_lim = 1'b1; e_idx = NBYTES - 1; stopped = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            if (!stopped) begin
                if (sa[k] != sb[k]) begin
                    e_eq = 1'b0; e_lt = (sa[k] < sb[k]); e_lim = 1'b0; e_idx = k; stopped = 1'b1;
                end else if (sa[k] == 8'h00) begin
                    e_lim = 1'b0; e_idx = k; stopped = 1'b1;
                end
            end
        end
        e_pops = e_idx / 4 + 1;
        load_queues();

        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        npops = 0; cyc = 0; last_pop = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            sta = (mode == 1) && ($urandom_range(0, 3) == 0);
            stb = (mode == 1) ? ($urandom_range(0, 3) == 0) : ((mode == 2) && cyc < 3);
            if (mode == 1) go = 1'($urandom_range(0, 1));
            a_valid = (qa.size() > 0) && !sta;
            b_valid = (qb.size() > 0) && !stb;
            a_data  = (qa.size() > 0) ? qa[0] : $urandom;
            b_data  = (qb.size() > 0) ? qb[0] : $urandom;
            #1;
            check({name, " pop_a"}, a_pop, a_valid && b_valid);
            check({name, " pop_b"}, b_pop, a_valid && b_valid);
            last_pop = a_pop;
            if (a_pop) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                npops++;
            end
            @(posedge clk);
            #1 go = 1'b0;
            cyc++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check({name, " done"}, done, 1'b1);
        check({name, " done_after_pop"}, last_pop, 1'b1);
        check({name, " busy"}, busy, 1'b0);
        check({name, " equal"}, equal, e_eq);
        check({name, " a_lt_b"}, a_lt_b, e_lt);
        check({name, " limit_hit"}, limit_hit, e_lim);
        check({name, " stop_index"}, stop_index, e_idx);
        check({name, " pops"}, npops, e_pops);
        if (mode == 2) check({name, " stall_latency"}, cyc, 4);

        // Result must hold with further words offered and no extra pops.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            a_valid = 1'b1; b_valid = 1'b1;
            #1;
            check({name, " no_extra_pop"}, {a_pop, b_pop}, 2'b00);
            check({name, " done_held"}, done, 1'b1);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic rand_strings();
        int la, p;
        la = $urandom_range(0, NBYTES + 4);
        for (int k = 0; k < NBYTES; k++)
            sa[k] = (k < la) ? 8'($urandom_range(65, 68)) : ((k == la) ? 8'h00 : 8'($urandom));
        for (int k = 0; k < NBYTES; k++) sb[k] = sa[k];
        if ($urandom_range(0, 3) != 0) begin
            p = $urandom_range(0, NBYTES - 1);
            case ($urandom_range(0, 2))
                0:       sb[p] = 8'h00;
                1:       sb[p] = 8'($urandom_range(65, 69));
                default: sa[p] = 8'($urandom);
            endcase
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pops", {a_pop, b_pop}, 0);
        check("rst_result", {equal, a_lt_b, limit_hit, stop_index}, 0);
        @(negedge clk);
        reset = 1'b0;

        put_str(0, "ABC.", 8'h00); put_str(1, "ABC.", 8'h00);
        run_case("equal", 0);
        put_str(0, "HELLOWOR", 8'h00); put_str(1, "HELLOWAR.", 8'h00);
        run_case("word2_mismatch", 0);
        put_str(0, "AB.x", 8'h00); put_str(1, "ABC.", 8'h00);
        run_case("short_a", 0);
        put_str(0, "", "A"); put_str(1, "", "A");
        run_case("limit", 0);
        put_str(0, "QRS.", 8'h00); put_str(1, "QRS.", 8'h00);
        run_case("stall", 2);

        // Reset in the middle of a run, after two word pairs.
        put_str(0, "", "Z"); put_str(1, "", "Z");
        load_queues();
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            a_valid = 1'b1; b_valid = 1'b1;
            a_data = qa[w]; b_data = qb[w];
            #1 check("pre_reset_pop", a_pop, 1);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun_busy", busy, 0);
        check("midrun_done", done, 0);
        check("midrun_pops", {a_pop, b_pop}, 0);
        check("midrun_result", {equal, a_lt_b, limit_hit, stop_index}, 0);
        @(negedge clk);
        reset = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        #1 check("post_reset_busy", busy, 0);
        put_str(0, "X.", 8'h00); put_str(1, "Y.", 8'h00);
        run_case("after_reset", 0);

        for (int t = 0; t < 30; t++) begin
            rand_strings();
            run_case($sformatf("rand%0d", t), (t % 3 == 0) ? 0 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
